clk_en_gen: RTL and testbench
=============================

# clk_en_gen

Multi-channel, runtime-programmable clock-enable generator. The successor to the single fixed-divisor enable divider. Each of `CHANNELS` independent channels produces a duty-cycle enable level and a one-cycle period-start tick from the system clock. Divisor and high time are written through a valid/ready config port and applied glitch-free at the channel's next period boundary. A global `sync` realigns all channels. It sits between the system clock domain and slow peripherals (UART baud, PWM, display scan) that need clock enables rather than derived clocks.

## Interface
- `CHANNELS`, 4, number of independent channels (1..16)
- `CNT_W`, 16, counter / divisor / high-time width
- `DEFAULT_DIV`, 2, per-channel divisor loaded at reset (≥ 2)
- `clk` input 1, system clock; all logic on rising edge
- `rst_n` input 1, reset, asynchronous assert, active-low
- `cfg_valid` input 1, config write request
- `cfg_ready` output 1, config write can be accepted
- `cfg_ch` input max(1,$clog2(CHANNELS)), target channel
- `cfg_div` input CNT_W, new period in clk cycles
- `cfg_high` input CNT_W, new high time in clk cycles
- `sync` input 1, restart all channels at count 0 (phase, see Configuration)
- `en` output CHANNELS, per-channel enable level
- `tick` output CHANNELS, per-channel one-cycle pulse at period start

## Operation
- Per-channel state: `cnt`, `act_div`, `act_high`, `pend_div`, `pend_high`, `pend_vld`.
- Reset values: `cnt`=0, `act_div`=DEFAULT_DIV, `act_high`=DEFAULT_DIV/2 (integer), `pend_vld`=0, `en`=0, `tick`=0, `cfg_ready`=1.
- Counting with `act_div` ≥ 2: `cnt` increments by 1 and wraps to 0 in the cycle `cnt == act_div-1` (wrap cycle).
- `act_div` = 1: `cnt` stays at 0; `tick` and `en` are high every cycle, unless `act_high`=0, which forces `en` to 0.
- `act_div` = 0: channel is stopped. `cnt` holds at 0; `en`=0 and `tick`=0.
- Registered outputs, updated every cycle from the current `cnt`:
  - `tick` <= (`act_div`≠0 && `cnt`==0)
  - `en` <= (`act_div`≠0 && `cnt` < min(`act_high`, `act_div`))
  - `act_high` ≥ `act_div` gives `en` constantly high; `act_high`=0 gives `en` constantly low while `tick` still runs.
- Config handshake: a write transfers on a cycle with `cfg_valid && cfg_ready`.
  - `cfg_ready` = !`pend_vld[cfg_ch]` (combinational on `cfg_ch`).
  - A transfer loads `pend_div`/`pend_high` and sets `pend_vld`.
  - `cfg_ch` ≥ CHANNELS: the write is accepted (`cfg_ready`=1) and discarded.
- Apply pending values:
  - In a wrap cycle, or in any cycle while stopped, or in a `sync` cycle: `act_*` <= `pend_*`, `pend_vld` <= 0, `cnt` <= 0 (phase).
  - The new period starts the next cycle.
  - Stopped → running: the first `tick` of the new setting appears 2 cycles after the write transfer.
- `sync`: all channels load `cnt` <= 0 (phase), apply any pending values, and ignore wrap.
- Arithmetic: all compares are unsigned CNT_W bits. `act_div-1` is evaluated only when `act_div` ≥ 2. There is no overflow, because `cnt` < `act_div` ≤ 2^CNT_W-1.

## Timing
- After reset release, first edge: `tick`=1 and `en`=(0<`act_high`). Period is `act_div` cycles; `en` is high for `act_high` cycles starting with the `tick` cycle.
- Outputs lag `cnt` by exactly 1 cycle. There is no combinational path from any input to `en`/`tick`.
- Simultaneous write and wrap/sync on the same channel: the write lands in pending and is **not** applied by that boundary. It is applied at the next boundary.
- Simultaneous `sync` and stopped channel: the channel remains stopped unless pending carries `act_div`≠0.
- Reset mid-period: all outputs drop to 0 immediately (asynchronous), and pending writes are lost.

## Configuration
- `CLK_EN_GEN_PHASE_EN` defined:
  - Adds input `cfg_phase` [CNT_W], written alongside `cfg_div` into a per-channel `pend_phase`/`act_phase`.
  - On `sync`, `cnt` loads `act_phase` mod `act_div`. Phase ≥ `act_div` is reduced with one conditional subtract, then clamped to `act_div-1`.
  - Wrap and stopped-apply still load 0.
- `CLK_EN_GEN_PHASE_EN` undefined: no `cfg_phase` port, and `sync` always loads 0.

## Test plan
- Reset release, all defaults (DEFAULT_DIV=2) -> every channel: `en` toggles 1,0,1,0 and `tick` matches `en`, starting on the first edge.
- ch1 write div=5 high=2 while running -> `cfg_ready` drops to 0 for ch1 until the next wrap. The new pattern (`en` 1,1,0,0,0 and `tick` every 5 cycles) starts the cycle after the wrap; ch0/2/3 are unaffected.
- ch2 write div=0, then later div=3 high=3 -> after the first write is applied, `en`/`tick` stay at 0. The first `tick` comes 2 cycles after the second transfer, with `en` constantly 1.
- Write div=4 to ch0 on the same cycle as its wrap, and pulse `sync` 6 cycles later -> the old divisor runs one more period, and all channels show `tick`=1 on the cycle after `sync`.
- With `CLK_EN_GEN_PHASE_EN`: ch3 div=8 high=4 phase=6, then `sync` -> the cycle after `sync`, ch3 `en`=0 and `tick`=0; its `tick` follows 2 cycles later.
- Assert `rst_n`=0 mid-period with a pending write -> `en`/`tick` read 0 during reset. After release, the divisor is DEFAULT_DIV and the pending write is discarded.

Source files
------------

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel programmable clock-enable generator with boundary-applied reconfiguration.
// Define CLK_EN_GEN_PHASE_EN to add a per-channel phase offset loaded on sync.
module clk_en_gen #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W-1:0]    cfg_high,
`ifdef CLK_EN_GEN_PHASE_EN
    input  logic [CNT_W-1:0]    cfg_phase,
`endif
    input  logic                sync,
    output logic [CHANNELS-1:0] en,
    output logic [CHANNELS-1:0] tick
);
    localparam int CH_P = 2 ** CH_W;
    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV / 2);
    logic [CHANNELS-1:0] pend_vld;
    logic [CH_P-1:0]     busy;
    // Nonexistent channel slots read as never-pending, so writes to them are accepted and dropped
    assign busy      = CH_P'(pend_vld);
    assign cfg_ready = !busy[cfg_ch];
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt, act_div, act_high, pend_div, pend_high, lim, sync_cnt;
        logic             stopped, wrap, apply, xfer, pv, en_r, tick_r;
        assign stopped = act_div == '0;
        assign wrap    = !stopped && cnt == act_div - 1'b1;
        assign apply   = pv && (wrap || stopped || sync);
        assign xfer    = cfg_valid && cfg_ready && cfg_ch == CH_W'(i);
        assign lim     = act_high < act_div ? act_high : act_div;
`ifdef CLK_EN_GEN_PHASE_EN
        logic [CNT_W-1:0] act_phase, pend_phase, nxt_div, nxt_phase, red;
        // A sync that also applies pending values aligns to the new setting
        assign nxt_div   = apply ? pend_div : act_div;
        assign nxt_phase = apply ? pend_phase : act_phase;
        assign red       = nxt_phase >= nxt_div ? nxt_phase - nxt_div : nxt_phase;
        assign sync_cnt  = nxt_div == '0 ? '0 : red >= nxt_div ? nxt_div - 1'b1 : red;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_phase  <= '0;
                pend_phase <= '0;
            end else begin
                if (apply) act_phase <= pend_phase;
                if (xfer) pend_phase <= cfg_phase;
            end
        end
`else
        assign sync_cnt = '0;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt       <= '0;
                act_div   <= RST_DIV;
                act_high  <= RST_HIGH;
                pend_div  <= '0;
                pend_high <= '0;
                pv        <= 1'b0;
                en_r      <= 1'b0;
                tick_r    <= 1'b0;
            end else begin
                tick_r <= !stopped && cnt == '0;
                en_r   <= !stopped && cnt < lim;
                cnt    <= sync ? sync_cnt : (wrap || stopped) ? '0 : cnt + 1'b1;
                pv     <= xfer || (pv && !apply);
                if (apply) begin
                    act_div  <= pend_div;
                    act_high <= pend_high;
                end
                if (xfer) begin
                    pend_div  <= cfg_div;
                    pend_high <= cfg_high;
                end
            end
        end
        assign pend_vld[i] = pv;
        assign en[i]       = en_r;
        assign tick[i]     = tick_r;
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: scoreboard bench for clk_en_gen driven by a cycle model of the channels.
`timescale 1ns/1ps
module tb_clk_en_gen;
    localparam int CH = 4;
    logic clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0, sync = 1'b0, cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [15:0] cfg_div = '0, cfg_high = '0;
`ifdef CLK_EN_GEN_PHASE_EN
    logic [15:0] cfg_phase = '0;
`endif
    logic [CH-1:0] en, tick, last_en, last_tick;
    int n_err = 0, n_chk = 0;
    int m_cnt[CH], m_div[CH], m_high[CH], m_aph[CH], m_pdiv[CH], m_phigh[CH], m_pph[CH];
    bit m_pv[CH];
    logic [2*CH-1:0] sb_q[$];

    always #5 clk = ~clk;

    clk_en_gen #(.CHANNELS(CH), .CNT_W(16), .DEFAULT_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
`ifdef CLK_EN_GEN_PHASE_EN
        .cfg_phase(cfg_phase),
`endif
        .sync(sync), .en(en), .tick(tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_div[c] = 2; m_high[c] = 1; m_aph[c] = 0; m_pv[c] = 0;
        end
    endfunction

    function automatic logic [2*CH-1:0] model_out();
        logic [CH-1:0] e, t;
        for (int c = 0; c < CH; c++) begin
            int l = m_high[c] < m_div[c] ? m_high[c] : m_div[c];
            e[c] = m_div[c] != 0 && m_cnt[c] < l;
            t[c] = m_div[c] != 0 && m_cnt[c] == 0;
        end
        return {e, t};
    endfunction

    function automatic int sync_pos(input int ph, input int div);
        int p;
        if (div == 0) return 0;
        p = ph >= div ? ph - div : ph;
        return p >= div ? div - 1 : p;
    endfunction

    function automatic void model_step(input bit v, input int ch, input int d, input int h, input int ph, input bit s);
        bit acc = v && !m_pv[ch];
        for (int c = 0; c < CH; c++) begin
            bit wr = m_div[c] != 0 && m_cnt[c] == m_div[c] - 1;
            bit st = m_div[c] == 0;
            if (m_pv[c] && (wr || st || s)) begin
                m_div[c] = m_pdiv[c]; m_high[c] = m_phigh[c]; m_aph[c] = m_pph[c]; m_pv[c] = 0;
            end
            if (s) m_cnt[c] = sync_pos(m_aph[c], m_div[c]);
            else if (wr || st) m_cnt[c] = 0;
            else m_cnt[c]++;
        end
        if (acc) begin
            m_pdiv[ch] = d; m_phigh[ch] = h; m_pv[ch] = 1;
`ifdef CLK_EN_GEN_PHASE_EN
            m_pph[ch] = ph;
`else
            m_pph[ch] = 0;
`endif
        end
    endfunction

    // Called at a negedge: drive, predict, clock once, compare at the next negedge
    task automatic step(input bit v, input int ch, input int d, input int h, input int ph, input bit s);
        logic [2*CH-1:0] exp;
        cfg_valid = v; cfg_ch = 2'(ch); cfg_div = 16'(d); cfg_high = 16'(h); sync = s;
`ifdef CLK_EN_GEN_PHASE_EN
        cfg_phase = 16'(ph);
`endif
        #1;
        chk("cfg_ready", cfg_ready, !m_pv[ch]);
        sb_q.push_back(model_out());
        model_step(v, ch, d, h, ph, s);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0; sync = 1'b0;
        exp = sb_q.pop_front();
        chk("en", en, exp[2*CH-1:CH]);
        chk("tick", tick, exp[CH-1:0]);
        last_en = en; last_tick = tick;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [4:0] pat;
        int k;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_en", en, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ready", cfg_ready, 1);
        rst_n = 1'b1;
        idle(1);
        chk("first_en", last_en, 4'hF);
        chk("first_tick", last_tick, 4'hF);
        idle(1);
        chk("second_en", last_en, 4'h0);
        chk("second_tick", last_tick, 4'h0);
        idle(3);
        step(1, 1, 5, 2, 0, 0);
        step(1, 1, 9, 9, 0, 0);
        idle(12);
        k = 0;
        while (!last_tick[1] && k < 6) begin idle(1); k++; end
        chk("ch1_tick_seen", last_tick[1], 1);
        pat[4] = last_en[1];
        for (int j = 3; j >= 0; j--) begin idle(1); pat[j] = last_en[1]; end
        chk("ch1_pattern", pat, 5'b11000);
        idle(1);
        chk("ch1_period", last_tick[1], 1);
        step(1, 2, 0, 0, 0, 0);
        idle(6);
        chk("ch2_stopped", {last_en[2], last_tick[2]}, 0);
        step(1, 2, 3, 3, 0, 0);
        chk("ch2_t0", last_tick[2], 0);
        idle(1);
        chk("ch2_t1", last_tick[2], 0);
        idle(1);
        chk("ch2_t2", last_tick[2], 1);
        chk("ch2_en", last_en[2], 1);
        idle(6);
        k = 0;
        while (m_cnt[0] != 1 && k < 4) begin idle(1); k++; end
        step(1, 0, 4, 2, 0, 0);
        idle(5);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        chk("sync_tick", last_tick, 4'hF);
        idle(8);
`ifdef CLK_EN_GEN_PHASE_EN
        step(1, 3, 8, 4, 6, 0);
        k = 0;
        while (m_pv[3] && k < 10) begin idle(1); k++; end
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        chk("ph_en", last_en[3], 0);
        chk("ph_t1", last_tick[3], 0);
        idle(1);
        chk("ph_t2", last_tick[3], 0);
        idle(1);
        chk("ph_t3", last_tick[3], 1);
        idle(4);
`endif
        repeat (300)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 6),
                 $urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 19) == 0);
        idle(10);
        k = 0;
        while (m_pv[1] && k < 20) begin idle(1); k++; end
        step(1, 1, 7, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", en, 0);
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("rel_en", last_en, 4'hF);
        chk("rel_tick", last_tick, 4'hF);
        idle(1);
        chk("rel_en2", last_en, 4'h0);
        idle(6);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
